// File: rtl/dispather_input.sv
// Descriptor dispatcher front end: takes the head of a showahead descriptor FIFO, asks the
// dispatcher for a cpuid, then forwards (or drops) the descriptor and pops the FIFO.
module dispather_input #(
  parameter logic [15:0] ACK_TIMEOUT = 16'd1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_desc_empty,
  input  logic [31:0] in_desc_q,
  output logic        out_desc_rdreq,
  output logic        out_input_ctl,
  output logic [4:0]  out_input_key,
  input  logic        in_input_ack,
  input  logic        in_input_valid,
  input  logic [4:0]  in_input_cpuid,
  input  logic        in_disp_almostfull,
  output logic        out_disp_wr,
  output logic [31:0] out_disp_data,
  output logic [4:0]  out_disp_cpuid,
  output logic [31:0] out_pass_cnt,
  output logic [31:0] out_drop_cnt
);

  typedef enum logic [1:0] {IDLE_S, REQ_S, REL_S, OUT_S} state_t;

  state_t      state_q, state_d;
  logic        ctl_q, ctl_d;
  logic [4:0]  key_q, key_d;
  logic        rdreq_q, rdreq_d;
  logic        wr_q, wr_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  cpuid_q, cpuid_d;
  logic [31:0] pass_q, pass_d;
  logic [31:0] drop_q, drop_d;
  logic [15:0] wait_q, wait_d;
  logic        lat_valid_q, lat_valid_d;
  logic [4:0]  lat_cpuid_q, lat_cpuid_d;

  always_comb begin
    state_d     = state_q;
    ctl_d       = ctl_q;
    key_d       = key_q;
    rdreq_d     = 1'b0;
    wr_d        = 1'b0;
    data_d      = data_q;
    cpuid_d     = cpuid_q;
    pass_d      = pass_q;
    drop_d      = drop_q;
    wait_d      = wait_q;
    lat_valid_d = lat_valid_q;
    lat_cpuid_d = lat_cpuid_q;
    case (state_q)
      IDLE_S: begin
        ctl_d = 1'b0;
        if (!in_desc_empty && !in_disp_almostfull) begin
          ctl_d   = 1'b1;
          key_d   = in_desc_q[4:0];
          wait_d  = 16'd0;
          state_d = REQ_S;
        end
      end
      REQ_S: begin
        // Ack is checked first so a late ack in the timeout cycle still counts.
        if (in_input_ack) begin
          lat_valid_d = in_input_valid;
          lat_cpuid_d = in_input_cpuid;
          ctl_d       = 1'b0;
          state_d     = REL_S;
        end else if (wait_q == ACK_TIMEOUT) begin
          lat_valid_d = 1'b0;
          ctl_d       = 1'b0;
          state_d     = REL_S;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      REL_S: begin
        // Strobes are set on entry so they are high exactly while in OUT_S.
        if (!in_input_ack) begin
          rdreq_d = 1'b1;
          if (lat_valid_q) begin
            wr_d    = 1'b1;
            data_d  = in_desc_q;
            cpuid_d = lat_cpuid_q;
            pass_d  = pass_q + 32'd1;
          end else begin
            drop_d  = drop_q + 32'd1;
          end
          state_d = OUT_S;
        end
      end
      OUT_S: begin
        state_d = IDLE_S;
      end
      default: begin
        ctl_d   = 1'b0;
        state_d = IDLE_S;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE_S;
      ctl_q       <= 1'b0;
      key_q       <= 5'd0;
      rdreq_q     <= 1'b0;
      wr_q        <= 1'b0;
      data_q      <= 32'd0;
      cpuid_q     <= 5'd0;
      pass_q      <= 32'd0;
      drop_q      <= 32'd0;
      wait_q      <= 16'd0;
      lat_valid_q <= 1'b0;
      lat_cpuid_q <= 5'd0;
    end else begin
      state_q     <= state_d;
      ctl_q       <= ctl_d;
      key_q       <= key_d;
      rdreq_q     <= rdreq_d;
      wr_q        <= wr_d;
      data_q      <= data_d;
      cpuid_q     <= cpuid_d;
      pass_q      <= pass_d;
      drop_q      <= drop_d;
      wait_q      <= wait_d;
      lat_valid_q <= lat_valid_d;
      lat_cpuid_q <= lat_cpuid_d;
    end
  end

  assign out_desc_rdreq = rdreq_q;
  assign out_input_ctl  = ctl_q;
  assign out_input_key  = key_q;
  assign out_disp_wr    = wr_q;
  assign out_disp_data  = data_q;
  assign out_disp_cpuid = cpuid_q;
  assign out_pass_cnt   = pass_q;
  assign out_drop_cnt   = drop_q;

endmodule

// File: tb/tb_dispather_input.sv
// Bench for dispather_input: FIFO and dispatcher models with a per-descriptor outcome scoreboard.
module tb_dispather_input;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_desc_empty;
  logic [31:0] in_desc_q;
  logic        out_desc_rdreq, out_input_ctl, out_disp_wr;
  logic [4:0]  out_input_key, out_disp_cpuid;
  logic        in_input_ack, in_input_valid, in_disp_almostfull;
  logic [4:0]  in_input_cpuid;
  logic [31:0] out_disp_data, out_pass_cnt, out_drop_cnt;

  always #5 clk = ~clk;

  dispather_input #(.ACK_TIMEOUT(16'(TO))) dut (
    .clk(clk), .reset(reset),
    .in_desc_empty(in_desc_empty), .in_desc_q(in_desc_q), .out_desc_rdreq(out_desc_rdreq),
    .out_input_ctl(out_input_ctl), .out_input_key(out_input_key),
    .in_input_ack(in_input_ack), .in_input_valid(in_input_valid), .in_input_cpuid(in_input_cpuid),
    .in_disp_almostfull(in_disp_almostfull),
    .out_disp_wr(out_disp_wr), .out_disp_data(out_disp_data), .out_disp_cpuid(out_disp_cpuid),
    .out_pass_cnt(out_pass_cnt), .out_drop_cnt(out_drop_cnt)
  );

  // FIFO contents with the dispatcher behaviour planned for each entry
  logic [31:0] fifo[$];
  int          p_delay[$], p_hold[$];
  logic        p_valid[$];
  logic [4:0]  p_cpu[$];

  int vectors = 0, miscompares = 0;
  int exp_pass = 0, exp_drop = 0;
  int cur_delay, cur_hold, cur_ctl_len, d_cnt, hold_left, ctl_len;
  logic        cur_pass, cur_valid;
  logic [4:0]  cur_cpu;
  logic [31:0] cur_data;
  logic ctl_prev = 0, rd_prev = 0, pending_pop = 0;
  int rd_seen = 0, wr_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic upd_head();
    in_desc_empty = (fifo.size() == 0);
    in_desc_q     = (fifo.size() == 0) ? 32'h0 : fifo[0];
  endtask

  task automatic push(input logic [31:0] d, input int dly, input int hold, input logic v,
                      input logic [4:0] c);
    fifo.push_back(d); p_delay.push_back(dly); p_hold.push_back(hold);
    p_valid.push_back(v); p_cpu.push_back(c);
    upd_head();
  endtask

  task automatic do_pop();
    if (pending_pop) begin
      void'(fifo.pop_front()); void'(p_delay.pop_front()); void'(p_hold.pop_front());
      void'(p_valid.pop_front()); void'(p_cpu.pop_front());
      pending_pop = 0;
      upd_head();
    end
  endtask

  task automatic step();
    logic ctl;
    @(posedge clk); #1;
    do_pop();
    ctl = out_input_ctl;
    if (ctl && !ctl_prev) begin
      chk("req_af_clear", {31'd0, in_disp_almostfull}, 32'd0);
      chk("req_fifo_nonempty", {31'd0, in_desc_empty}, 32'd0);
      chk("req_key", {27'd0, out_input_key}, {27'd0, in_desc_q[4:0]});
      cur_delay = p_delay[0]; cur_hold = p_hold[0]; cur_valid = p_valid[0];
      cur_cpu = p_cpu[0]; cur_data = fifo[0];
      cur_pass = (cur_delay <= TO) && cur_valid;
      cur_ctl_len = ((cur_delay < TO) ? cur_delay : TO) + 1;
      d_cnt = 0; ctl_len = 0;
    end
    if (ctl) ctl_len++;
    if (!ctl && ctl_prev) chk("ctl_length", ctl_len, cur_ctl_len);
    if (out_desc_rdreq) begin
      rd_seen++;
      if (out_disp_wr) wr_seen++;
      chk("rdreq_single", {31'd0, rd_prev}, 32'd0);
      chk("rdreq_after_ack_low", {31'd0, in_input_ack}, 32'd0);
      chk("wr_outcome", {31'd0, out_disp_wr}, {31'd0, cur_pass});
      if (cur_pass) begin
        chk("wr_data", out_disp_data, cur_data);
        chk("wr_cpuid", {27'd0, out_disp_cpuid}, {27'd0, cur_cpu});
        exp_pass++;
      end else exp_drop++;
      chk("pass_cnt", out_pass_cnt, exp_pass);
      chk("drop_cnt", out_drop_cnt, exp_drop);
      pending_pop = 1;
    end else if (out_disp_wr) begin
      chk("wr_without_rdreq", {31'd0, out_disp_wr}, 32'd0);
    end
    // dispatcher model: ack after the planned delay, release after the planned hold
    if (ctl) begin
      if (!in_input_ack && d_cnt == cur_delay) begin
        in_input_ack = 1; in_input_valid = cur_valid; in_input_cpuid = cur_cpu;
        hold_left = cur_hold;
      end
      d_cnt++;
    end else if (in_input_ack) begin
      if (hold_left > 0) hold_left--;
      else begin in_input_ack = 0; in_input_valid = 0; in_input_cpuid = 0; end
    end
    ctl_prev = ctl; rd_prev = out_desc_rdreq;
  endtask

  task automatic do_reset();
    reset = 0; in_input_ack = 0; in_input_valid = 0; in_input_cpuid = 0;
    @(posedge clk); #1;
    do_pop();
    chk("rst_ctl", {31'd0, out_input_ctl}, 32'd0);
    chk("rst_rdreq", {31'd0, out_desc_rdreq}, 32'd0);
    chk("rst_wr", {31'd0, out_disp_wr}, 32'd0);
    chk("rst_key", {27'd0, out_input_key}, 32'd0);
    chk("rst_cpuid", {27'd0, out_disp_cpuid}, 32'd0);
    chk("rst_data", out_disp_data, 32'd0);
    chk("rst_pass", out_pass_cnt, 32'd0);
    chk("rst_drop", out_drop_cnt, 32'd0);
    exp_pass = 0; exp_drop = 0; ctl_prev = 0; rd_prev = 0;
    reset = 1;
  endtask

  task automatic drain(input bit rand_af);
    bit busy;
    busy = 1;
    for (int i = 0; i < 4000 && busy; i++) begin
      in_disp_almostfull = rand_af ? ($urandom_range(0, 3) == 0) : 1'b0;
      step();
      busy = (fifo.size() != 0) || pending_pop || out_input_ctl || in_input_ack;
    end
    in_disp_almostfull = 0;
    chk("drain_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int r0, w0;
    reset = 0; in_input_ack = 0; in_input_valid = 0; in_input_cpuid = 0;
    in_disp_almostfull = 0;
    upd_head();
    do_reset();
    do_reset();
    // basic pass, explicit valid drop, timeout drop
    push(32'h0000_0003, 3, 0, 1'b1, 5'd5);
    drain(0);
    chk("pass_one", out_pass_cnt, 32'd1);
    push(32'h0000_0011, 2, 1, 1'b0, 5'd7);
    drain(0);
    chk("drop_invalid", out_drop_cnt, 32'd1);
    push(32'hABCD_0009, 1000, 0, 1'b1, 5'd2);
    drain(0);
    chk("drop_timeout", out_drop_cnt, 32'd2);
    chk("pass_unchanged", out_pass_cnt, 32'd1);
    // ack exactly at the timeout cycle still wins
    push(32'h1234_5604, TO, 0, 1'b1, 5'd9);
    drain(0);
    chk("ack_at_timeout", out_pass_cnt, 32'd2);
    // almostfull blocks the request until it clears
    in_disp_almostfull = 1;
    push(32'h0000_001F, 0, 0, 1'b1, 5'd31);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("af_hold_ctl", {31'd0, out_input_ctl}, 32'd0);
    end
    in_disp_almostfull = 0;
    step();
    chk("af_release_ctl", {31'd0, out_input_ctl}, 32'd1);
    drain(0);
    // four back-to-back descriptors, ack held after ctl falls
    r0 = rd_seen; w0 = wr_seen;
    for (int i = 0; i < 4; i++) push(32'h5A00_0000 | 32'(i * 7 + 1), i, 2, 1'b1, 5'(i + 1));
    drain(0);
    chk("b2b_rdreq_cnt", rd_seen - r0, 4);
    chk("b2b_wr_cnt", wr_seen - w0, 4);
    // reset while a request is outstanding
    push(32'h0000_0016, 4, 0, 1'b1, 5'd12);
    step(); step();
    chk("pre_rst_ctl", {31'd0, out_input_ctl}, 32'd1);
    r0 = rd_seen;
    do_reset();
    chk("rst_no_pop", fifo.size(), 1);
    chk("rst_no_rdreq", rd_seen - r0, 0);
    drain(0);
    chk("rst_rereq_pass", out_pass_cnt, 32'd1);
    // randomized traffic
    for (int i = 0; i < 40; i++)
      push($urandom, $urandom_range(0, TO + 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
           5'($urandom));
    drain(1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dispather_input.md
DISPATHER_INPUT -- requirements
Module: dispather_input

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16'd1023, max cycles to wait for in_input_ack before the descriptor is dropped.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 in_desc_empty  input  1  descriptor FIFO empty flag (showahead FIFO).
REQ-005 in_desc_q  input  32  descriptor at FIFO head; bits [4:0] = ingress port key.
REQ-006 out_desc_rdreq  output  1  one-cycle pop of FIFO head.
REQ-007 out_input_ctl  output  1  cpuid request to dispatcher.
REQ-008 out_input_key  output  5  key presented with request.
REQ-009 in_input_ack  input  1  dispatcher acknowledge.
REQ-010 in_input_valid  input  1  allocated cpuid is usable.
REQ-011 in_input_cpuid  input  5  allocated cpuid.
REQ-012 in_disp_almostfull  input  1  downstream queue cannot accept a new descriptor.
REQ-013 out_disp_wr  output  1  one-cycle write strobe to downstream.
REQ-014 out_disp_data  output  32  forwarded descriptor.
REQ-015 out_disp_cpuid  output  5  cpuid attached to forwarded descriptor.
REQ-016 out_pass_cnt  output  32  descriptors forwarded.
REQ-017 out_drop_cnt  output  32  descriptors dropped (invalid cpuid or timeout).

Function
REQ-018 States: IDLE_S, REQ_S, REL_S, OUT_S; all outputs registered.
REQ-019 IDLE_S: when in_desc_empty=0 and in_disp_almostfull=0, set out_input_ctl=1, out_input_key=in_desc_q[4:0], clear wait counter, go REQ_S; else stay, ctl=0.
REQ-020 REQ_S: hold ctl=1 and key stable; dispatcher may cycle internally any number of times without ack (round-robin skip of invalid cpuids).
REQ-021 REQ_S on in_input_ack=1: latch in_input_valid and in_input_cpuid, set ctl=0, go REL_S.
REQ-022 REQ_S: 16-bit wait counter increments each cycle without ack; when counter = ACK_TIMEOUT with no ack, set ctl=0, mark result invalid (timeout), go REL_S.
REQ-023 Ack and timeout in same cycle: ack wins; latched valid used.
REQ-024 REL_S: wait until in_input_ack=0 (dispatcher back in idle) then go OUT_S; ctl stays 0.
REQ-025 OUT_S, latched valid=1: one-cycle out_disp_wr=1, out_disp_data=in_desc_q, out_disp_cpuid=latched cpuid, out_desc_rdreq=1, out_pass_cnt+1; go IDLE_S.
REQ-026 OUT_S, latched valid=0 or timeout: out_desc_rdreq=1, out_disp_wr=0, out_drop_cnt+1; go IDLE_S.
REQ-027 out_desc_rdreq and out_disp_wr are single-cycle pulses; never asserted outside OUT_S.
REQ-028 At most one descriptor in flight; FIFO head is not popped until OUT_S; back-to-back descriptors take minimum 1 idle cycle between OUT_S and next request.
REQ-029 in_disp_almostfull sampled only in IDLE_S; a request already issued completes regardless.
REQ-030 Counters wrap 32'hFFFFFFFF -> 0 without saturation.
REQ-031 Illegal state: all strobes 0, ctl=0, go IDLE_S.

Reset
REQ-032 reset=0 at a rising edge: state IDLE_S; out_input_ctl, out_desc_rdreq, out_disp_wr=0; out_input_key, out_disp_cpuid=0; out_disp_data=0; both counters=0; wait counter=0.
REQ-033 Reset mid-request drops ctl next edge; FIFO head not popped; descriptor re-requested after reset release.

Verification
REQ-034 Desc 32'h0000_0003, ack after 3 cycles with valid=1 cpuid=5 -> ctl high until ack, ctl falls, after ack low one wr pulse data=32'h3 cpuid=5, rdreq pulse same cycle, pass_cnt=1.
REQ-035 Ack with valid=0 -> no wr, one rdreq pulse, drop_cnt=1, pass_cnt=0.
REQ-036 ACK_TIMEOUT=8, ack never asserted -> ctl high 9 cycles then low, rdreq pulse, drop_cnt=1.
REQ-037 in_disp_almostfull=1 with FIFO non-empty -> ctl stays 0; deassert -> request next cycle.
REQ-038 Four descriptors back-to-back, ack held high 2 extra cycles after ctl falls -> wr only after ack low, exactly 4 wr and 4 rdreq pulses, key matches each head.
REQ-039 Reset asserted in REQ_S -> ctl=0 and no rdreq; after release same head requested again, final pass_cnt=1.
